// File: rtl/seq_mul_n.sv
// seq_mul_n: W x W shift-and-add multiplier, one multiplier bit per clock, LSB first.
// Ports: clk, rst_a (async, active-high), load, a (multiplier), b (multiplicand),
//        op (2W product), ready_out (result valid), busy (multiply in progress).
// Parameters: W (2..32), EARLY_TERM (finish once remaining multiplier bits are zero).
// Optional macro SEQ_MUL_SIGNED_EN adds input sgn for two's-complement operation.
module seq_mul_n #(
    parameter int W          = 4,
    parameter bit EARLY_TERM = 1'b0
) (
    input  logic           clk,
    input  logic           rst_a,
    input  logic           load,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic           sgn,
`endif
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] op,
    output logic           ready_out,
    output logic           busy
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] mcand_q;
    logic [2*W-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic           neg_q;

    logic           accept;
    logic           last;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic           neg_d;
    logic [2*W-1:0] sum;
    logic [2*W-1:0] prod;

    // Operand conditioning: signed mode multiplies magnitudes and
    // remembers whether the result must be negated at completion.
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude in W bits.
    always_comb begin
        a_mag = a;
        b_mag = b;
        neg_d = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
        if (sgn) begin
            if (a[W-1]) a_mag = -a;
            if (b[W-1]) b_mag = -b;
            neg_d = a[W-1] ^ b[W-1];
        end
`endif
    end

    // One partial product per cycle; mcand_q is pre-shifted so the
    // accumulator add never needs the bit index.
    always_comb begin
        sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod = neg_q ? -sum : sum;
        last = (cnt_q == CW'(W - 1));
        if (EARLY_TERM && (mplier_q[W-1:1] == '0)) last = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            mplier_q  <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            op        <= '0;
            ready_out <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            mplier_q  <= a_mag;
            mcand_q   <= {{W{1'b0}}, b_mag};
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= neg_d;
            ready_out <= 1'b0;
            busy      <= 1'b1;
        end else if (state_q == RUN) begin
            acc_q    <= sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last) begin
                op        <= prod;
                ready_out <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_n.sv
// tb_seq_mul_n: random and directed checks of seq_mul_n (W=4) against a
// behavioural model; one instance with EARLY_TERM=0, one with EARLY_TERM=1.
module tb_seq_mul_n;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       ld0, ld1;
    logic       sg0, sg1;
    logic [3:0] a0, b0, a1, b1;
    logic [7:0] op0, op1;
    logic       rdy0, rdy1, bz0, bz1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_mul_n #(.W(4), .EARLY_TERM(1'b0)) u_fix (
        .clk       (clk),
        .rst_a     (rst_a),
        .load      (ld0),
`ifdef SEQ_MUL_SIGNED_EN
        .sgn       (sg0),
`endif
        .a         (a0),
        .b         (b0),
        .op        (op0),
        .ready_out (rdy0),
        .busy      (bz0)
    );

    seq_mul_n #(.W(4), .EARLY_TERM(1'b1)) u_early (
        .clk       (clk),
        .rst_a     (rst_a),
        .load      (ld1),
`ifdef SEQ_MUL_SIGNED_EN
        .sgn       (sg1),
`endif
        .a         (a1),
        .b         (b1),
        .op        (op1),
        .ready_out (rdy1),
        .busy      (bz1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic sgn_eff(input logic s);
`ifdef SEQ_MUL_SIGNED_EN
        return s;
`else
        return 1'b0 & s;
`endif
    endfunction

    function automatic logic [7:0] ref_prod(input logic [3:0] x, input logic [3:0] y,
                                            input logic s);
        int sx, sy;
        sx = int'(x);
        sy = int'(y);
        if (s && x[3]) sx = sx - 16;
        if (s && y[3]) sy = sy - 16;
        return 8'(sx * sy);
    endfunction

    // Cycles to completion: 4 fixed, or 1 + index of the highest set
    // magnitude bit when early termination is on.
    function automatic int ref_lat(input int d, input logic [3:0] x, input logic s);
        int m, l;
        if (d == 0) return 4;
        m = int'(x);
        if (s && x[3]) m = 16 - m;
        l = 1;
        for (int i = 1; i < 4; i++) if (m >= (1 << i)) l = i + 1;
        return l;
    endfunction

    task automatic mul(input int d, input logic [3:0] x, input logic [3:0] y,
                       input logic s, output int lat, output logic [7:0] prod);
        logic [7:0] prev;
        logic       r, bz;
        prev = d ? op1 : op0;
        if (d == 0) begin
            a0 = x; b0 = y; sg0 = s; ld0 = 1'b1;
        end else begin
            a1 = x; b1 = y; sg1 = s; ld1 = 1'b1;
        end
        @(posedge clk); #1;
        ld0 = 1'b0;
        ld1 = 1'b0;
        chk("load_busy", int'(d ? bz1 : bz0), 1);
        chk("load_rdy", int'(d ? rdy1 : rdy0), 0);
        chk("load_op_hold", int'(d ? op1 : op0), int'(prev));
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            r  = d ? rdy1 : rdy0;
            bz = d ? bz1 : bz0;
            chk("excl", int'(r & bz), 0);
            if (r) begin
                lat = i;
                break;
            end
            chk("run_busy", int'(bz), 1);
            chk("run_op_hold", int'(d ? op1 : op0), int'(prev));
        end
        prod = d ? op1 : op0;
    endtask

    task automatic run_chk(input int d, input logic [3:0] x, input logic [3:0] y,
                           input logic s);
        int         lat;
        logic [7:0] p;
        logic       se;
        se = sgn_eff(s);
        mul(d, x, y, s, lat, p);
        chk("prod", int'(p), int'(ref_prod(x, y, se)));
        chk("lat", lat, ref_lat(d, x, se));
    endtask

    initial begin
        int         lat;
        logic [7:0] p;
        rst_a = 1'b1;
        ld0 = 1'b0; ld1 = 1'b0;
        sg0 = 1'b0; sg1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op0", int'(op0), 0);
        chk("rst_rdy0", int'(rdy0), 0);
        chk("rst_bz0", int'(bz0), 0);
        chk("rst_op1", int'(op1), 0);
        chk("rst_rdy1", int'(rdy1), 0);
        chk("rst_bz1", int'(bz1), 0);
        @(negedge clk);
        rst_a = 1'b0;

        // Max operands, fixed latency, load on first edge after reset.
        mul(0, 4'd15, 4'd15, 1'b0, lat, p);
        chk("ff_prod", int'(p), 8'hE1);
        chk("ff_lat", lat, 4);

        // Load issued while ready_out is high.
        mul(0, 4'd3, 4'd3, 1'b0, lat, p);
        chk("b2b_first", int'(p), 8'h09);
        mul(0, 4'd2, 4'd2, 1'b0, lat, p);
        chk("b2b_second", int'(p), 8'h04);
        chk("b2b_lat", lat, 4);

        // Load during RUN must be ignored.
        a0 = 4'd3; b0 = 4'd5; ld0 = 1'b1;
        @(posedge clk); #1;
        ld0 = 1'b0;
        @(posedge clk); #1;
        a0 = 4'd1; b0 = 4'd1; ld0 = 1'b1;
        @(posedge clk); #1;
        ld0 = 1'b0;
        lat = -1;
        for (int i = 3; i <= 8; i++) begin
            @(posedge clk); #1;
            if (rdy0) begin
                lat = i;
                break;
            end
        end
        chk("ign_lat", lat, 4);
        chk("ign_prod", int'(op0), 8'h0F);

        // Asynchronous reset two cycles into RUN.
        a0 = 4'd5; b0 = 4'd7; ld0 = 1'b1;
        @(posedge clk); #1;
        ld0 = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        chk("arst_op", int'(op0), 0);
        chk("arst_rdy", int'(rdy0), 0);
        chk("arst_bz", int'(bz0), 0);
        @(negedge clk);
        rst_a = 1'b0;
        mul(0, 4'd2, 4'd3, 1'b0, lat, p);
        chk("arst_after", int'(p), 8'h06);
        chk("arst_after_lat", lat, 4);

        // Early termination.
        mul(1, 4'd1, 4'd9, 1'b0, lat, p);
        chk("et_prod", int'(p), 8'h09);
        chk("et_lat", lat, 1);
        mul(1, 4'd0, 4'd11, 1'b0, lat, p);
        chk("et_zero", int'(p), 8'h00);
        chk("et_zero_lat", lat, 1);

`ifdef SEQ_MUL_SIGNED_EN
        mul(0, 4'h8, 4'h8, 1'b1, lat, p);
        chk("sg_nn", int'(p), 8'h40);
        mul(0, 4'h8, 4'h7, 1'b1, lat, p);
        chk("sg_np", int'(p), 8'hC8);
        mul(0, 4'hF, 4'hF, 1'b0, lat, p);
        chk("sg_uns", int'(p), 8'hE1);
`endif

        for (int i = 0; i < 30; i++) begin
            run_chk(0, 4'($urandom_range(15)), 4'($urandom_range(15)),
                    1'($urandom_range(1)));
            run_chk(1, 4'($urandom_range(15)), 4'($urandom_range(15)),
                    1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mul_n.md
SEQ_MUL_N -- requirements
Module: seq_mul_n

Interface
REQ-001 SHALL have parameter W, default 4, operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter EARLY_TERM, default 0; 1 enables early completion when the remaining multiplier bits are zero.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_a, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port load, input, 1, start request; operands sampled when accepted.
REQ-006 SHALL have port a, input, W, multiplier operand.
REQ-007 SHALL have port b, input, W, multiplicand operand.
REQ-008 SHALL have port op, output reg, 2W, product result.
REQ-009 SHALL have port ready_out, output reg, 1, result valid; held high until the next accepted load.
REQ-010 SHALL have port busy, output reg, 1, high while a multiplication is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; transitions: IDLE->RUN on load; RUN->DONE on last iteration; DONE->RUN on load; otherwise hold.
REQ-012 SHALL accept load only in IDLE or DONE; load while in RUN is ignored with no effect on operands, counter or outputs.
REQ-013 On an accepted load at edge k, SHALL capture a and b, clear the internal accumulator, set busy=1 and ready_out=0 at edge k.
REQ-014 SHALL process one multiplier bit per cycle, LSB first: if the bit is 1, add the multiplicand shifted by the bit index into a 2W-bit accumulator; no bits are dropped.
REQ-015 With EARLY_TERM=0, SHALL update op, set ready_out=1 and busy=0 at edge k+W, for a fixed latency of W cycles.
REQ-016 With EARLY_TERM=1, SHALL complete at the first edge after which all unprocessed multiplier bits are zero; latency is 1..W cycles (a=0 gives 1 cycle).
REQ-017 SHALL leave op holding the last completed product until the next completion; op is not cleared by load.
REQ-018 The product SHALL be exact: op = a*b modulo 2^(2W), which is always exact for unsigned operands.
REQ-019 busy and ready_out SHALL never be high simultaneously.

Reset
REQ-020 Assertion of rst_a at any time, including mid-RUN, SHALL immediately force op=0, ready_out=0, busy=0, clear the accumulator and counter, and enter IDLE.
REQ-021 After rst_a deasserts, SHALL accept load on the first rising clk edge.

Configuration
REQ-022 Macro SEQ_MUL_SIGNED_EN, when defined, SHALL add input port sgn (1 bit), sampled on accepted load; sgn=1 treats a, b and op as two's complement.
REQ-023 With SEQ_MUL_SIGNED_EN and sgn=1, SHALL multiply operand magnitudes and negate the result at completion when the operand signs differ; latency is unchanged from REQ-015/016.
REQ-024 Without SEQ_MUL_SIGNED_EN, port sgn SHALL NOT exist and all operation is unsigned.

Verification (W=4 unless stated)
REQ-025 a=15, b=15, load pulsed 1 cycle, EARLY_TERM=0 -> ready_out rises exactly 4 cycles after the load edge; op=8'hE1; busy high for those 4 cycles.
REQ-026 load re-pulsed mid-RUN with a=1, b=1 after a=3, b=5 started -> op=8'h0F; the second load is ignored.
REQ-027 rst_a asserted asynchronously 2 cycles into RUN -> op=0, ready_out=0, busy=0 without waiting for a clk edge; a new load of a=2, b=3 then yields op=8'h06.
REQ-028 EARLY_TERM=1, a=1, b=9 -> ready_out after 1 cycle with op=8'h09; a=0 -> ready_out after 1 cycle with op=8'h00.
REQ-029 SEQ_MUL_SIGNED_EN defined, sgn=1: a=-8, b=-8 -> op=8'h40; a=-8, b=7 -> op=8'hC8; sgn=0, a=4'hF, b=4'hF -> op=8'hE1.
REQ-030 Back-to-back: load issued the cycle ready_out is high (a=2, b=2 after a=3, b=3) -> ready_out drops at the next edge; op stays 8'h09 until it updates to 8'h04.
